// File: rtl/data_ram_pkg.sv
// Shared mode/state definitions and the access-size helper for the MEM-stage data RAM.
package data_ram_pkg;

    localparam logic [1:0] MODE_BYTE  = 2'b00;
    localparam logic [1:0] MODE_HALF  = 2'b01;
    localparam logic [1:0] MODE_WORD  = 2'b10;
    localparam logic [1:0] MODE_DWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    function automatic logic [3:0] size_of(input logic [1:0] mode);
        logic [3:0] size;
        case (mode)
            MODE_BYTE: size = 4'd1;
            MODE_HALF: size = 4'd2;
            MODE_WORD: size = 4'd4;
            default:   size = 4'd8;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Request/response handshake bundle between the pipeline MEM stage and the data RAM.
interface data_ram_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [1:0]        req_mode;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_rw, req_mode, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_rw, req_mode, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_ram_extend.sv
// Picks the accessed bytes out of the left-justified raw read and sign/zero-extends them to 64 bits.
module data_ram_extend
    import data_ram_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [1:0]  mode,
    input  logic        sign_ext,
    output logic [63:0] result
);

    logic fill_s;

    // Raw data is left-justified, so the sign bit is always raw[63].
    always_comb begin
        result = 64'h0;
        fill_s = sign_ext & raw[63];
        case (mode)
            MODE_BYTE: result = {{56{fill_s}}, raw[63:56]};
            MODE_HALF: result = {{48{fill_s}}, raw[63:48]};
            MODE_WORD: result = {{32{fill_s}}, raw[63:32]};
            default:   result = raw;
        endcase
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Byte-addressable big-endian data memory with valid/ready request and response handshakes.
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 256,
    parameter int WORD_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    data_ram_ctrl_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_t          state_r;
    state_t          state_s;

    logic            rw_r;
    logic [1:0]      mode_r;
    logic            signed_r;
    logic [AW-1:0]   idx_r;
    logic [63:0]     wdata_r;
    logic [31:0]     raw_hi_r;

    logic            req_ready_r;
    logic            resp_valid_r;
    logic [63:0]     resp_rdata_r;
    logic            resp_err_r;

    logic            accept_s;
    logic [3:0]      req_size_s;
    logic [ADDR_W:0] req_end_s;
    logic            req_err_s;

    logic [AW-1:0]   beat_base_s;
    logic [31:0]     beat_data_s;
    logic [3:0]      byte_en_s;
    logic            mem_we_s;
    logic [31:0]     rd_word_s;
    logic [63:0]     raw_s;
    logic [63:0]     ext_s;
    logic [63:0]     rdata_s;
    logic            err_s;

    logic [7:0]      mem [DEPTH];

    assign accept_s = bus.req_valid && req_ready_r;

    // Alignment and range check on the live request; the end address is one bit wider so it never wraps.
    always_comb begin
        req_size_s = size_of(bus.req_mode);
        req_end_s  = {1'b0, bus.req_addr} + {{(ADDR_W-3){1'b0}}, req_size_s};
        req_err_s  = (|(bus.req_addr[3:0] & (req_size_s - 4'd1)))
                  || (req_end_s > (ADDR_W+1)'(DEPTH));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = req_err_s ? ST_RESP : ST_BEAT0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BEAT0: state_s = (mode_r == MODE_DWORD) ? ST_BEAT1 : ST_RESP;
            ST_BEAT1: state_s = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request capture on the accept edge; the first read beat is parked for the doubleword case.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_r     <= 1'b0;
            mode_r   <= MODE_BYTE;
            signed_r <= 1'b0;
            idx_r    <= '0;
            wdata_r  <= 64'h0;
            raw_hi_r <= 32'h0;
        end else begin
            if (accept_s) begin
                rw_r     <= bus.req_rw;
                mode_r   <= bus.req_mode;
                signed_r <= bus.req_signed;
                idx_r    <= bus.req_addr[AW-1:0];
                wdata_r  <= bus.req_wdata;
            end
            if (state_r == ST_BEAT0) begin
                raw_hi_r <= rd_word_s;
            end
        end
    end

    // Beat address, left-justified write data and byte lanes for the current beat.
    always_comb begin
        beat_base_s = idx_r;
        beat_data_s = wdata_r[31:0];
        byte_en_s   = 4'b1111;
        if (state_r == ST_BEAT1) begin
            beat_base_s = idx_r + AW'(WORD_BYTES);
            beat_data_s = wdata_r[31:0];
            byte_en_s   = 4'b1111;
        end else begin
            case (mode_r)
                MODE_BYTE: begin
                    beat_data_s = {wdata_r[7:0], 24'h0};
                    byte_en_s   = 4'b0001;
                end
                MODE_HALF: begin
                    beat_data_s = {wdata_r[15:0], 16'h0};
                    byte_en_s   = 4'b0011;
                end
                MODE_WORD: begin
                    beat_data_s = wdata_r[31:0];
                    byte_en_s   = 4'b1111;
                end
                default: begin
                    beat_data_s = wdata_r[63:32];
                    byte_en_s   = 4'b1111;
                end
            endcase
        end
        mem_we_s = rw_r && ((state_r == ST_BEAT0) || (state_r == ST_BEAT1));
    end

    // Byte-lane writes; gated by rst_n so a beat abandoned by reset never commits.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (byte_en_s[i]) begin
                    mem[beat_base_s + AW'(i)] <= beat_data_s[31-8*i -: 8];
                end
            end
        end
    end

    // Big-endian beat read and assembly of the left-justified raw doubleword.
    always_comb begin
        rd_word_s = 32'h0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_word_s[31-8*i -: 8] = mem[beat_base_s + AW'(i)];
        end
        if (state_r == ST_BEAT1) begin
            raw_s = {raw_hi_r, rd_word_s};
        end else begin
            raw_s = {rd_word_s, 32'h0};
        end
    end

    data_ram_extend u_extend (
        .raw      (raw_s),
        .mode     (mode_r),
        .sign_ext (signed_r),
        .result   (ext_s)
    );

    // Response payload loaded on entry to RESP, held until the handshake, then cleared.
    always_comb begin
        rdata_s = resp_rdata_r;
        err_s   = resp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    rdata_s = 64'h0;
                    err_s   = req_err_s;
                end else begin
                    rdata_s = 64'h0;
                    err_s   = 1'b0;
                end
            end
            ST_BEAT0: begin
                rdata_s = (rw_r || (mode_r == MODE_DWORD)) ? 64'h0 : ext_s;
                err_s   = 1'b0;
            end
            ST_BEAT1: begin
                rdata_s = rw_r ? 64'h0 : ext_s;
                err_s   = 1'b0;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    rdata_s = 64'h0;
                    err_s   = 1'b0;
                end else begin
                    rdata_s = resp_rdata_r;
                    err_s   = resp_err_r;
                end
            end
            default: begin
                rdata_s = 64'h0;
                err_s   = 1'b0;
            end
        endcase
    end

    // Registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 64'h0;
            resp_err_r   <= 1'b0;
        end else begin
            req_ready_r  <= (state_s == ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP);
            resp_rdata_r <= rdata_s;
            resp_err_r   <= err_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: a byte-array model predicts every response and its latency.
module tb_data_ram_ctrl;
    import data_ram_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    data_ram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    data_ram_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORD_BYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        string       name;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_mem [DEPTH];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         last_accept = 0;

    function automatic logic model_err(input logic [1:0] mode, input logic [31:0] addr);
        int unsigned sz;
        sz = 32'd1 << mode;
        return ((addr % sz) != 32'd0) || (({32'h0, addr} + 64'(sz)) > 64'(DEPTH));
    endfunction

    function automatic logic [63:0] model_read(input logic [1:0] mode, input logic sgn,
                                               input logic [31:0] addr);
        logic [63:0] v;
        int          sz;
        v  = 64'h0;
        sz = 1 << mode;
        for (int i = 0; i < sz; i++) v = {v[55:0], model_mem[addr[7:0] + 8'(i)]};
        if (sgn && (sz < 8) && v[8*sz-1]) v = v | ~((64'h1 << (8*sz)) - 64'h1);
        return v;
    endfunction

    task automatic model_write(input logic [1:0] mode, input logic [31:0] addr, input logic [63:0] wdata);
        int sz;
        sz = 1 << mode;
        for (int i = 0; i < sz; i++) model_mem[addr[7:0] + 8'(i)] = wdata[8*(sz-1-i) +: 8];
    endtask

    task automatic do_req(input logic rw, input logic [1:0] mode, input logic sgn, input logic [31:0] addr,
                          input logic [63:0] wdata, input int hold, input string name);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        bit   stable;
        e.err   = model_err(mode, addr);
        e.rdata = (e.err || rw) ? 64'h0 : model_read(mode, sgn, addr);
        e.lat   = e.err ? 1 : ((mode == MODE_DWORD) ? 3 : 2);
        e.name  = name;
        if (!e.err && rw) model_write(mode, addr, wdata);
        sb_q.push_back(e);

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_rw     = rw;
        bus.req_mode   = mode;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = (hold == 0);
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.req_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL %s accept_timeout: req_ready got %b required 1", name, bus.req_ready);
            bus.req_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        last_accept    = cyc_cnt;
        bus.req_valid  = 1'b0;
        bus.req_rw     = 1'($urandom);
        bus.req_mode   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = {$urandom, $urandom};

        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = bus.resp_valid;
        end
        got = sb_q.pop_front();
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s resp_timeout: resp_valid got 0 required 1", got.name);
            return;
        end
        if (cyc !== got.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", got.name, cyc, got.lat);
        end
        n_cmp++;
        if (bus.resp_rdata !== got.rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h required %h", got.name, bus.resp_rdata, got.rdata);
        end
        n_cmp++;
        if (bus.resp_err !== got.err) begin
            n_fail++;
            $display("FAIL %s err: got %b required %b", got.name, bus.resp_err, got.err);
        end

        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                stable = bus.resp_valid && !bus.req_ready
                      && (bus.resp_rdata === got.rdata) && (bus.resp_err === got.err);
                n_cmp++;
                if (!stable) begin
                    n_fail++;
                    $display("FAIL %s hold_cycle%0d: valid=%b ready=%b rdata=%h required valid=1 ready=0 rdata=%h",
                             got.name, k, bus.resp_valid, bus.req_ready, bus.resp_rdata, got.rdata);
                end
            end
            bus.resp_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s release: valid=%b ready=%b required valid=0 ready=1",
                         got.name, bus.resp_valid, bus.req_ready);
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_mode = MODE_BYTE; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 64'h0; bus.resp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready); end
        n_cmp++;
        if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b required 0", bus.resp_valid); end
        n_cmp++;
        if (bus.resp_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", bus.resp_rdata); end
        n_cmp++;
        if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", bus.resp_err); end
    endtask

    task automatic test_init();
        for (int a = 0; a < 64; a += 8) do_req(1'b1, MODE_DWORD, 1'b0, 32'(a), {$urandom, $urandom}, 0, "init_dw");
        do_req(1'b1, MODE_DWORD, 1'b0, 32'd248, 64'h1122334455667788, 0, "init_top");
    endtask

    task automatic test_word_bytes();
        do_req(1'b1, MODE_WORD, 1'b0, 32'd8, 64'hDEADBEEF, 0, "word_wr8");
        for (int i = 0; i < 4; i++) do_req(1'b0, MODE_BYTE, 1'b0, 32'(8 + i), 64'h0, 0, "byte_rd");
        do_req(1'b0, MODE_WORD, 1'b0, 32'd8, 64'h0, 0, "word_rd8");
    endtask

    task automatic test_extension();
        do_req(1'b1, MODE_HALF, 1'b0, 32'd4, 64'h8001, 0, "half_wr4");
        do_req(1'b0, MODE_HALF, 1'b1, 32'd4, 64'h0, 0, "half_rd_signed");
        do_req(1'b0, MODE_HALF, 1'b0, 32'd4, 64'h0, 0, "half_rd_unsigned");
        do_req(1'b0, MODE_BYTE, 1'b0, 32'd6, 64'h0, 0, "byte6_untouched");
        do_req(1'b0, MODE_BYTE, 1'b0, 32'd7, 64'h0, 0, "byte7_untouched");
    endtask

    task automatic test_dword();
        do_req(1'b1, MODE_DWORD, 1'b0, 32'd16, 64'h0123456789ABCDEF, 0, "dw_wr16");
        do_req(1'b0, MODE_DWORD, 1'b1, 32'd16, 64'h0, 0, "dw_rd16");
        do_req(1'b0, MODE_BYTE, 1'b0, 32'd16, 64'h0, 0, "byte16");
        do_req(1'b0, MODE_BYTE, 1'b0, 32'd23, 64'h0, 0, "byte23");
        do_req(1'b0, MODE_BYTE, 1'b1, 32'd23, 64'h0, 0, "byte23_signed");
    endtask

    task automatic test_errors();
        logic [63:0] got_top;
        logic [63:0] exp_top;
        do_req(1'b0, MODE_WORD, 1'b0, 32'd2, 64'h0, 0, "err_word_mis");
        do_req(1'b1, MODE_DWORD, 1'b0, 32'd252, 64'hFFFF_FFFF_FFFF_FFFF, 0, "err_dw_252");
        for (int i = 0; i < 8; i++) begin
            got_top[63-8*i -: 8] = dut.mem[248 + i];
            exp_top[63-8*i -: 8] = model_mem[248 + i];
        end
        n_cmp++;
        if (got_top !== exp_top) begin
            n_fail++;
            $display("FAIL err_mem_248_255: got %h required %h", got_top, exp_top);
        end
        do_req(1'b0, MODE_HALF, 1'b0, 32'd255, 64'h0, 0, "err_half_255");
        do_req(1'b0, MODE_BYTE, 1'b0, 32'd255, 64'h0, 0, "byte_255_ok");
        do_req(1'b0, MODE_BYTE, 1'b0, 32'd256, 64'h0, 0, "err_byte_256");
        do_req(1'b0, MODE_WORD, 1'b0, 32'hFFFF_FFFC, 64'h0, 0, "err_nowrap");
        do_req(1'b0, MODE_DWORD, 1'b0, 32'd248, 64'h0, 0, "dw_rd_248_edge");
    endtask

    task automatic test_backpressure();
        do_req(1'b0, MODE_WORD, 1'b0, 32'd8, 64'h0, 5, "backpressure");
    endtask

    task automatic test_back_to_back();
        int s0;
        int s1;
        int s2;
        do_req(1'b0, MODE_WORD, 1'b0, 32'd8, 64'h0, 0, "b2b_word");
        s0 = last_accept;
        do_req(1'b0, MODE_DWORD, 1'b0, 32'd16, 64'h0, 0, "b2b_dw");
        s1 = last_accept;
        do_req(1'b0, MODE_BYTE, 1'b1, 32'd9, 64'h0, 0, "b2b_byte");
        s2 = last_accept;
        n_cmp++;
        if (s1 - s0 !== 3) begin n_fail++; $display("FAIL b2b_spacing_word: got %0d required 3", s1 - s0); end
        n_cmp++;
        if (s2 - s1 !== 4) begin n_fail++; $display("FAIL b2b_spacing_dw: got %0d required 4", s2 - s1); end
    endtask

    task automatic test_reset_midop();
        int          cyc;
        bit          any_valid;
        logic [63:0] got_m;
        logic [63:0] exp_m;
        model_write(MODE_WORD, 32'd32, 64'hA1A2A3A4);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_mode = MODE_DWORD; bus.req_signed = 1'b0;
        bus.req_addr = 32'd32; bus.req_wdata = 64'hA1A2A3A4_B5B6B7B8; bus.resp_ready = 1'b1;
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        any_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid) any_valid = 1'b1;
        end
        n_cmp++;
        if (any_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resp: resp_valid seen %b required 0", any_valid); end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", bus.req_ready); end
        for (int i = 0; i < 8; i++) begin
            got_m[63-8*i -: 8] = dut.mem[32 + i];
            exp_m[63-8*i -: 8] = model_mem[32 + i];
        end
        n_cmp++;
        if (got_m !== exp_m) begin n_fail++; $display("FAIL midrst_mem_32_39: got %h required %h", got_m, exp_m); end
        do_req(1'b0, MODE_WORD, 1'b0, 32'd32, 64'h0, 0, "midrst_rd32");
        do_req(1'b0, MODE_WORD, 1'b0, 32'd36, 64'h0, 0, "midrst_rd36");
    endtask

    initial begin
        test_reset();
        test_init();
        test_word_bytes();
        test_extension();
        test_dword();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
